// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants, collision priority and read-mux select for regfile_sb
package regfile_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_NUM_REGS = 8;

  // Which write port owns a register when both target it in one cycle.
  typedef enum logic {
    PORT_A_WINS = 1'b0,
    PORT_B_WINS = 1'b1
  } collide_prio_e;

  localparam collide_prio_e COLLIDE_PRIO = PORT_B_WINS;

  // Source selected by a bypassed read.
  typedef enum logic [1:0] {
    SEL_ZERO = 2'd0,
    SEL_B    = 2'd1,
    SEL_A    = 2'd2,
    SEL_ARR  = 2'd3
  } rd_sel_e;

  // Width-agnostic read priority shared by rd1, rd2 and the debug capture:
  // hardwired zero first, then the colliding winner, then the other port,
  // then the stored array value.
  function automatic rd_sel_e read_sel(input logic zero_hit, input logic b_hit, input logic a_hit);
    rd_sel_e sel;
    if (zero_hit) begin
      sel = SEL_ZERO;
    end else if (COLLIDE_PRIO == PORT_B_WINS) begin
      sel = b_hit ? SEL_B : (a_hit ? SEL_A : SEL_ARR);
    end else begin
      sel = a_hit ? SEL_A : (b_hit ? SEL_B : SEL_ARR);
    end
    return sel;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register pending-write bits and RAW hazard flags
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                eff_a,
  input  logic [ADDR_W-1:0]   wa_a,
  input  logic                eff_b,
  input  logic [ADDR_W-1:0]   wa_b,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_rd,
  input  logic [ADDR_W-1:0]   ra1,
  input  logic [ADDR_W-1:0]   ra2,
  output logic                rs1_busy,
  output logic                rs2_busy,
  output logic [NUM_REGS-1:0] busy_vec
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                issue_ok;

  assign issue_ok = issue_valid && !((ZERO_REG != 0) && (issue_rd == '0));

  // Next busy state: completing writes clear, a new issue sets last so it
  // supersedes a write retiring to the same register.
  always_comb begin
    busy_d = busy_q;
    if (eff_a)    busy_d[wa_a]     = 1'b0;
    if (eff_b)    busy_d[wa_b]     = 1'b0;
    if (issue_ok) busy_d[issue_rd] = 1'b1;
  end

  // Scoreboard register; reset dominates everything else.
  always_ff @(posedge clk) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  // A pending register is not a hazard when its producer retires this cycle,
  // since the bypass already delivers the value.
  always_comb begin
    rs1_busy = busy_q[ra1] && !(eff_a && (wa_a == ra1)) && !(eff_b && (wa_b == ra1))
               && !((ZERO_REG != 0) && (ra1 == '0));
    rs2_busy = busy_q[ra2] && !(eff_a && (wa_a == ra2)) && !(eff_b && (wa_b == ra2))
               && !((ZERO_REG != 0) && (ra2 == '0));
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - dual-write, dual-read register file with bypass, scoreboard and debug port
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   ra1,
  input  logic [ADDR_W-1:0]   ra2,
  output logic [DATA_W-1:0]   rd1,
  output logic [DATA_W-1:0]   rd2,
  output logic                rs1_busy,
  output logic                rs2_busy,
  input  logic                we_a,
  input  logic [ADDR_W-1:0]   wa_a,
  input  logic [DATA_W-1:0]   wd_a,
  input  logic                we_b,
  input  logic [ADDR_W-1:0]   wa_b,
  input  logic [DATA_W-1:0]   wd_b,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_rd,
  input  logic [ADDR_W-1:0]   dbg_addr,
  output logic [DATA_W-1:0]   dbg_data,
  output logic [NUM_REGS-1:0] busy_vec
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] dbg_q, dbg_d;
  logic              eff_a, eff_b, same_addr, wr_a_ok, wr_b_ok;

  // Writes to a hardwired-zero R0 are dropped entirely, including for bypass
  // and scoreboard purposes.
  always_comb begin
    eff_a     = we_a && !((ZERO_REG != 0) && (wa_a == '0));
    eff_b     = we_b && !((ZERO_REG != 0) && (wa_b == '0));
    same_addr = eff_a && eff_b && (wa_a == wa_b);
    wr_a_ok   = eff_a && !(same_addr && (COLLIDE_PRIO == PORT_B_WINS));
    wr_b_ok   = eff_b && !(same_addr && (COLLIDE_PRIO == PORT_A_WINS));
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] val;
    case (read_sel((ZERO_REG != 0) && (addr == '0), eff_b && (wa_b == addr), eff_a && (wa_a == addr)))
      SEL_ZERO: val = '0;
      SEL_B:    val = wd_b;
      SEL_A:    val = wd_a;
      default:  val = regs_q[addr];
    endcase
    return val;
  endfunction

  // Next array contents from the surviving write ports.
  always_comb begin
    regs_d = regs_q;
    if (wr_a_ok) regs_d[wa_a] = wd_a;
    if (wr_b_ok) regs_d[wa_b] = wd_b;
  end

  // Bypassed combinational reads and the value captured by the debug port.
  always_comb begin
    rd1   = read_port(ra1);
    rd2   = read_port(ra2);
    dbg_d = read_port(dbg_addr);
  end

  // Data array and debug register; reset wins over writes and capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      dbg_q <= '0;
    end else begin
      regs_q <= regs_d;
      dbg_q  <= dbg_d;
    end
  end

  assign dbg_data = dbg_q;

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .eff_a       (eff_a),
    .wa_a        (wa_a),
    .eff_b       (eff_b),
    .wa_b        (wa_b),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .ra1         (ra1),
    .ra2         (ra2),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .busy_vec    (busy_vec)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed and randomized self-checking bench for regfile_sb
module tb_regfile_sb;

  localparam int DW = 8;
  localparam int NR = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] ra1, ra2, wa_a, wa_b, issue_rd, dbg_addr;
  logic          we_a, we_b, issue_valid;
  logic [DW-1:0] wd_a, wd_b;
  logic [DW-1:0] rd1, rd2, dbg_data;
  logic          rs1_busy, rs2_busy;
  logic [NR-1:0] busy_vec;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: plain arrays updated by the architectural rules.
  logic [DW-1:0] m_regs [NR];
  logic          m_busy [NR];
  logic [DW-1:0] m_dbg;

  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(DW), .NUM_REGS(NR), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a), .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data), .busy_vec(busy_vec)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic bit m_write_hits(input logic we, input logic [AW-1:0] wa, input logic [AW-1:0] a);
    return we && (wa != 0) && (wa == a);
  endfunction

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
    if (a == 0)                        return '0;
    if (m_write_hits(we_b, wa_b, a))   return wd_b;
    if (m_write_hits(we_a, wa_a, a))   return wd_a;
    return m_regs[a];
  endfunction

  function automatic logic m_hazard(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
    if (m_write_hits(we_a, wa_a, a) || m_write_hits(we_b, wa_b, a)) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic [NR-1:0] m_busy_vec();
    logic [NR-1:0] v;
    for (int i = 0; i < NR; i++) v[i] = m_busy[i];
    return v;
  endfunction

  // Advance the reference by one clock edge using the current inputs.
  task automatic m_edge();
    if (reset) begin
      for (int i = 0; i < NR; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 1'b0;
      end
      m_dbg = '0;
    end else begin
      m_dbg = m_read(dbg_addr);
      if (we_a && wa_a != 0) begin m_regs[wa_a] = wd_a; m_busy[wa_a] = 1'b0; end
      if (we_b && wa_b != 0) begin m_regs[wa_b] = wd_b; m_busy[wa_b] = 1'b0; end
      if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
    end
  endtask

  task automatic idle();
    reset = 0; we_a = 0; we_b = 0; issue_valid = 0;
    wa_a = 0; wa_b = 0; wd_a = 0; wd_b = 0; issue_rd = 0;
    ra1 = 0; ra2 = 0; dbg_addr = 0;
  endtask

  // Check combinational outputs against the model, clock once, check registered outputs.
  task automatic tick();
    #1;
    if (!reset) begin
      check("rd1", rd1, m_read(ra1));
      check("rd2", rd2, m_read(ra2));
      check("rs1_busy", rs1_busy, m_hazard(ra1));
      check("rs2_busy", rs2_busy, m_hazard(ra2));
    end
    m_edge();
    @(posedge clk);
    #1;
    check("dbg_data", dbg_data, m_dbg);
    check("busy_vec", busy_vec, m_busy_vec());
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin m_regs[i] = 'x; m_busy[i] = 1'bx; end
    idle();
    reset = 1;
    @(posedge clk); #1;
    tick();
    reset = 0;

    // Load every register with 0xFF and mark some busy, then reset.
    for (int i = 0; i < NR; i += 2) begin
      idle();
      we_a = 1; wa_a = AW'(i);     wd_a = 8'hFF;
      we_b = 1; wa_b = AW'(i + 1); wd_b = 8'hFF;
      issue_valid = 1; issue_rd = AW'(i + 1);
      tick();
    end
    idle(); reset = 1;
    tick();
    check("rst_busy_vec", busy_vec, 0);
    for (int i = 0; i < NR; i++) begin
      idle(); ra1 = AW'(i); dbg_addr = AW'(i);
      tick();
      check("rst_rd1", rd1, 0);
      check("rst_dbg", dbg_data, 0);
    end

    // Same-cycle bypass on port A, then array read.
    idle(); we_a = 1; wa_a = 3; wd_a = 8'h5A; ra1 = 3;
    #1 check("bypass_a_rd1", rd1, 8'h5A);
    tick();
    idle(); ra1 = 3;
    #1 check("array_rd1", rd1, 8'h5A);
    tick();

    // Write collision: port B wins.
    idle(); we_a = 1; wa_a = 5; wd_a = 8'h11; we_b = 1; wa_b = 5; wd_b = 8'h22; ra2 = 5;
    #1 check("collide_rd2", rd2, 8'h22);
    tick();
    idle(); ra1 = 5; dbg_addr = 5;
    #1 check("collide_array", rd1, 8'h22);
    tick();
    check("collide_dbg", dbg_data, 8'h22);

    // Hardwired zero register ignores writes and issues.
    idle(); we_a = 1; wa_a = 0; wd_a = 8'h77; issue_valid = 1; issue_rd = 0; ra1 = 0;
    #1 check("zero_rd1", rd1, 0);
    check("zero_rs1_busy", rs1_busy, 0);
    tick();
    check("zero_busy0", busy_vec[0], 0);

    // Issue to r2, hazard visible next cycle, resolved by a port B writeback.
    idle(); issue_valid = 1; issue_rd = 2; ra1 = 2;
    #1 check("issue_same_cycle", rs1_busy, 0);
    tick();
    idle(); ra1 = 2;
    #1 check("issue_rs1_busy", rs1_busy, 1);
    tick();
    idle(); ra1 = 2;
    tick();
    idle(); we_b = 1; wa_b = 2; wd_b = 8'h9C; ra1 = 2;
    #1 check("resolve_rs1_busy", rs1_busy, 0);
    check("resolve_rd1", rd1, 8'h9C);
    tick();
    check("resolve_busy2", busy_vec[2], 0);

    // Issue and write to r4 in the same cycle: set wins.
    idle(); issue_valid = 1; issue_rd = 4; we_a = 1; wa_a = 4; wd_a = 8'h33;
    tick();
    check("setwin_busy4", busy_vec[4], 1);
    idle(); ra2 = 4; dbg_addr = 4;
    #1 check("setwin_rs2_busy", rs2_busy, 1);
    check("setwin_rd2", rd2, 8'h33);
    tick();
    check("setwin_dbg", dbg_data, 8'h33);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      reset       = ($urandom_range(0, 49) == 0);
      we_a        = $urandom_range(0, 1) == 1;
      we_b        = $urandom_range(0, 1) == 1;
      issue_valid = $urandom_range(0, 2) == 0;
      wa_a        = AW'($urandom);
      wa_b        = ($urandom_range(0, 3) == 0) ? wa_a : AW'($urandom);
      wd_a        = DW'($urandom);
      wd_b        = DW'($urandom);
      issue_rd    = AW'($urandom);
      ra1         = ($urandom_range(0, 2) == 0) ? wa_a : AW'($urandom);
      ra2         = ($urandom_range(0, 2) == 0) ? wa_b : AW'($urandom);
      dbg_addr    = AW'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
